// File: rtl/pipe_ex.sv
// Execute stage: latches ID operands, computes the ALU result, runs a 32-step
// restoring divider for div/mod and issues the data SRAM request toward MEM.
module pipe_ex #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        from_allowin,
   input  logic        from_valid,
   input  logic [31:0] from_pc,
   input  logic [11:0] alu_op_ID,
   input  logic [31:0] alu_src1_ID,
   input  logic [31:0] alu_src2_ID,
   input  logic [3:0]  div_op_ID,
   input  logic [4:0]  load_op_ID,
   input  logic [2:0]  store_op_ID,
   input  logic [31:0] rkd_value_ID,
   input  logic        rf_we_ID,
   input  logic [4:0]  rf_waddr_ID,
   input  logic        res_from_mem_ID,
   output logic        to_valid,
   output logic        to_allowin,
   output logic        data_sram_en,
   output logic [3:0]  data_sram_we,
   output logic [31:0] data_sram_addr,
   output logic [31:0] data_sram_wdata,
   output logic [31:0] pc_EX,
   output logic [4:0]  load_op_EX,
   output logic [31:0] alu_result_EX,
   output logic        rf_we_EX,
   output logic [4:0]  rf_waddr_EX,
   output logic        res_from_mem_EX
);

   localparam int CNT_W = $clog2(DIV_STEPS + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   logic        valid_reg;
   logic [31:0] pc_reg, src1_reg, src2_reg, rkd_reg;
   logic [11:0] alu_op_reg;
   logic [3:0]  div_op_reg;
   logic [4:0]  load_op_reg;
   logic [2:0]  store_op_reg;
   logic        rf_we_reg, res_from_mem_reg;
   logic [4:0]  rf_waddr_reg;

   div_state_t  div_state_reg, div_state_next;
   logic [CNT_W-1:0] div_cnt_reg;
   logic [31:0] quot_reg, rem_reg, divisor_reg;
   logic        q_neg_reg, r_neg_reg;

   logic is_div, div_done, ready_go, accept, div_start, leave;
   logic id_signed, id_a_neg, id_b_neg;
   logic [32:0] div_shift, div_diff;
   logic [31:0] div_quot, div_rem, div_result;
   logic [31:0] add_result, alu_result;
   logic is_load, is_store;

   assign is_div     = |div_op_reg;
   assign div_done   = (div_state_reg == DONE);
   assign ready_go   = valid_reg && (!is_div || div_done);
   assign to_allowin = !valid_reg || (ready_go && from_allowin);
   assign to_valid   = valid_reg && ready_go;
   assign accept     = from_valid && to_allowin;
   assign div_start  = accept && (|div_op_ID);
   assign leave      = ready_go && from_allowin;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg        <= 1'b0;
         pc_reg           <= '0;
         src1_reg         <= '0;
         src2_reg         <= '0;
         rkd_reg          <= '0;
         alu_op_reg       <= '0;
         div_op_reg       <= '0;
         load_op_reg      <= '0;
         store_op_reg     <= '0;
         rf_we_reg        <= 1'b0;
         rf_waddr_reg     <= '0;
         res_from_mem_reg <= 1'b0;
      end else begin
         if (to_allowin)
            valid_reg <= from_valid;
         if (accept) begin
            pc_reg           <= from_pc;
            src1_reg         <= alu_src1_ID;
            src2_reg         <= alu_src2_ID;
            rkd_reg          <= rkd_value_ID;
            alu_op_reg       <= alu_op_ID;
            div_op_reg       <= div_op_ID;
            load_op_reg      <= load_op_ID;
            store_op_reg     <= store_op_ID;
            rf_we_reg        <= rf_we_ID;
            rf_waddr_reg     <= rf_waddr_ID;
            res_from_mem_reg <= res_from_mem_ID;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         div_state_reg <= IDLE;
      else
         div_state_reg <= div_state_next;
   end

   always_comb begin
      div_state_next = div_state_reg;
      unique case (div_state_reg)
         IDLE: if (div_start) div_state_next = BUSY;
         BUSY: if (div_cnt_reg == CNT_W'(DIV_STEPS - 1)) div_state_next = DONE;
         DONE: begin
            if (div_start)  div_state_next = BUSY;
            else if (leave) div_state_next = IDLE;
         end
         default: div_state_next = IDLE;
      endcase
   end

   // div.w / mod.w are bits 0 and 1; operands enter as magnitudes
   assign id_signed = div_op_ID[0] | div_op_ID[1];
   assign id_a_neg  = id_signed && alu_src1_ID[31];
   assign id_b_neg  = id_signed && alu_src2_ID[31];

   // rem < divisor always holds, so bit 32 of the difference is a clean borrow
   assign div_shift = {rem_reg, quot_reg[31]};
   assign div_diff  = div_shift - {1'b0, divisor_reg};

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_reg <= '0;
         quot_reg    <= '0;
         rem_reg     <= '0;
         divisor_reg <= '0;
         q_neg_reg   <= 1'b0;
         r_neg_reg   <= 1'b0;
      end else if (div_start) begin
         div_cnt_reg <= '0;
         quot_reg    <= id_a_neg ? -alu_src1_ID : alu_src1_ID;
         divisor_reg <= id_b_neg ? -alu_src2_ID : alu_src2_ID;
         rem_reg     <= '0;
         q_neg_reg   <= id_a_neg ^ id_b_neg;
         r_neg_reg   <= id_a_neg;
      end else if (div_state_reg == BUSY) begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
         if (div_diff[32]) begin
            rem_reg  <= div_shift[31:0];
            quot_reg <= {quot_reg[30:0], 1'b0};
         end else begin
            rem_reg  <= div_diff[31:0];
            quot_reg <= {quot_reg[30:0], 1'b1};
         end
      end
   end

   assign div_quot   = q_neg_reg ? -quot_reg : quot_reg;
   assign div_rem    = r_neg_reg ? -rem_reg  : rem_reg;
   assign div_result = (div_op_reg[1] | div_op_reg[3]) ? div_rem : div_quot;

   assign add_result = src1_reg + src2_reg;

   always_comb begin
      alu_result = '0;
      case (alu_op_reg)
         12'h001: alu_result = add_result;
         12'h002: alu_result = src1_reg - src2_reg;
         12'h004: alu_result = ($signed(src1_reg) < $signed(src2_reg)) ? 32'd1 : 32'd0;
         12'h008: alu_result = (src1_reg < src2_reg) ? 32'd1 : 32'd0;
         12'h010: alu_result = src1_reg & src2_reg;
         12'h020: alu_result = ~(src1_reg | src2_reg);
         12'h040: alu_result = src1_reg | src2_reg;
         12'h080: alu_result = src1_reg ^ src2_reg;
         12'h100: alu_result = src1_reg << src2_reg[4:0];
         12'h200: alu_result = src1_reg >> src2_reg[4:0];
         12'h400: alu_result = $signed(src1_reg) >>> src2_reg[4:0];
         12'h800: alu_result = src2_reg;
         default: alu_result = '0;
      endcase
   end

   assign alu_result_EX = is_div ? div_result : alu_result;

   assign is_load  = |load_op_reg;
   assign is_store = |store_op_reg;

   assign data_sram_en   = valid_reg && ready_go && from_allowin && (is_load || is_store);
   assign data_sram_addr = add_result;

   // store_op bit 2 = st.b, bit 1 = st.h, bit 0 = st.w
   always_comb begin
      data_sram_we = 4'b0000;
      if (store_op_reg[2])
         data_sram_we = 4'b0001 << add_result[1:0];
      else if (store_op_reg[1])
         data_sram_we = add_result[1] ? 4'b1100 : 4'b0011;
      else if (store_op_reg[0])
         data_sram_we = 4'b1111;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
         assign data_sram_wdata[8*gi +: 8] =
            store_op_reg[2] ? rkd_reg[7:0] :
            store_op_reg[1] ? rkd_reg[8*(gi % 2) +: 8] :
                              rkd_reg[8*gi +: 8];
      end
   endgenerate

   assign pc_EX           = pc_reg;
   assign load_op_EX      = load_op_reg;
   assign rf_we_EX        = rf_we_reg;
   assign rf_waddr_EX     = rf_waddr_reg;
   assign res_from_mem_EX = res_from_mem_reg;

endmodule

// File: doc/pipe_ex.md
Name: pipe_EX

Overview:
Execute stage of the 5-stage pipeline, sitting between the ID stage and the MEM stage. It latches decoded operands from ID through the valid/allowin handshake and computes the ALU result. It runs a multi-cycle iterative divider for div/mod instructions, issues the data SRAM request for loads and stores, and forwards load_op, result and writeback controls to MEM.

Parameters:
DIV_STEPS, 32, number of one-bit restoring iterations per division (fixed to data width).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
from_allowin  input  1  MEM stage accepts data this cycle
from_valid  input  1  ID stage has a valid instruction to hand over
from_pc  input  32  PC of the ID instruction
alu_op_ID  input  12  one-hot: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui
alu_src1_ID  input  32  operand 1
alu_src2_ID  input  32  operand 2
div_op_ID  input  4  one-hot: div.w,mod.w,div.wu,mod.wu; 0 = not a divide
load_op_ID  input  5  ld.b,ld.bu,ld.h,ld.hu,ld.w one-hot (bits 4..0)
store_op_ID  input  3  st.b,st.h,st.w one-hot (bits 2..0)
rkd_value_ID  input  32  store data
rf_we_ID / rf_waddr_ID / res_from_mem_ID  input  1/5/1  writeback controls
to_valid  output  1  EX result may leave to MEM
to_allowin  output  1  EX accepts from ID
data_sram_en  output  1  SRAM request
data_sram_we  output  4  byte write enables
data_sram_addr  output  32  byte address
data_sram_wdata  output  32  aligned store data
pc_EX, load_op_EX, alu_result_EX  output  32/5/32  to MEM
rf_we_EX, rf_waddr_EX, res_from_mem_EX  output  1/5/1  to MEM

Behaviour:
- Clock is clk; reset is reset, synchronous, active-high.
- Reset clears valid, all stage registers, divider state and counter. pc_EX, load_op_EX, rf_we_EX, rf_waddr_EX and res_from_mem_EX all reset to 0. Reset during a division aborts it.
- Handshake:
  - ready_go = valid && (!is_div || div_done).
  - to_allowin = !valid || (ready_go && from_allowin).
  - to_valid = valid && ready_go.
  - On a to_allowin edge, valid <= from_valid.
  - Stage registers load only when from_valid && to_allowin.
- ALU (combinational on latched operands): add/sub use 32-bit wraparound; slt is signed and sltu unsigned, both giving a 0/1 result. sll/srl/sra shift by src2[4:0]. lui passes src2. An all-zero alu_op gives 0.
- alu_result_EX equals the divider result when is_div, otherwise the ALU result.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE->BUSY on the edge that latches a div instruction. Operand magnitudes are captured on that edge (absolute value for signed ops) and the counter is set to 0.
  - In BUSY, one restoring step per cycle and counter++. After DIV_STEPS steps -> DONE; div_done=1 only in DONE.
  - DONE->IDLE when the instruction leaves (ready_go && from_allowin). DONE->BUSY directly if a new div is latched on that same edge.
  - Latency: ready_go is first high 32 cycles after valid rises.
  - Sign fix: quotient negated when signs differ (signed ops); remainder takes the dividend's sign.
  - Divide by zero: quotient magnitude 0xFFFFFFFF and remainder = |dividend|, then sign fix.
  - 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0.
- Memory request:
  - data_sram_en = valid && ready_go && from_allowin && (load || store), so it is issued only on the handoff cycle.
  - data_sram_addr = ALU add result (full 32 bits).
  - data_sram_we is 0 for loads.
  - st.b: we = 4'b0001 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - st.h: we = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rkd[15:0]}}; addr[0] is ignored.
  - st.w: we = 4'b1111, wdata = rkd.
  - No misalignment exception.
- Stall: while from_allowin=0, all outputs hold and no SRAM request is issued.

Test Plan:
- add 0x7FFFFFFF + 1, MEM always ready -> alu_result_EX=0x80000000, to_valid high one cycle after valid, data_sram_en=0.
- st.b addr=0x1003, rkd=0x000000AB with from_allowin low for 3 cycles, then high -> en=0 during stall; then en=1, we=4'b1000, wdata=0xABABABAB, to_allowin low during stall.
- div.w -7 / 2 -> after 32 busy cycles alu_result_EX=0xFFFFFFFD; mod.w gives 0xFFFFFFFF; to_valid low for cycles 1..31.
- div.wu 0x10 / 0 -> 0xFFFFFFFF; mod.wu 0x10 / 0 -> 0x10; div.w 0x80000000 / -1 -> 0x80000000.
- Back-to-back div.wu 100/7 then div.wu 100/9 with MEM ready -> results 14 then 11, second starts BUSY on the first's handoff edge.
- Assert reset at BUSY cycle 10, then issue add 1+2 -> valid=0 after reset, next result 3 with no stale div_done.
